mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single-ported 4 KB data/instruction memory between the instruction-fetch (I) and load/store (D) requesters.
//  - Arbitrates round-robin and latches the winning request.
//  - Drives the memory's addr/data/size/we/re inputs for one cycle, then returns registered read data with a one-cycle ack.
//  - Sits between the core's fetch/LSU stages and the memory instance.
// PARAMETERS
//  MEM_ADDR   16'h1000  value of addr[31:16] that selects the memory region (must match the memory's MEM_ADDR)
//  RR_INIT    1'b1      last-granted value after reset (1 = D, so I wins the first tie)
// PORTS
//  clock      in   1   single clock; everything updates on posedge
//  reset      in   1   synchronous, active-high
//  i_req      in   1   fetch request; hold with i_addr until i_ack
//  i_addr     in   32  fetch byte address (word access, read-only)
//  i_ack      out  1   one-cycle completion pulse
//  i_rdata    out  32  fetch data, valid while i_ack=1
//  i_err      out  1   request rejected; valid while i_ack=1
//  d_req      in   1   load/store request; hold payload until d_ack
//  d_we       in   1   1 = store, 0 = load
//  d_addr     in   32  byte address
//  d_wdata    in   32  store data, right-justified for byte/half
//  d_size     in   2   0=byte 1=half 2=unaligned 3=word
//  d_ack      out  1   one-cycle completion pulse
//  d_rdata    out  32  full load word, valid while d_ack=1
//  d_err      out  1   request rejected; valid while d_ack=1
//  mem_addr   out  32  memory address
//  mem_wdata  out  32  memory write data
//  mem_size   out  2   memory size
//  mem_we     out  1   memory write enable
//  mem_re     out  1   memory read enable
//  mem_rdata  in   32  memory read data (combinational from mem_addr)
//  busy       out  1   1 when state != IDLE
// BEHAVIOUR
//  Reset values:
//   - state=IDLE, last_gnt=RR_INIT.
//   - All outputs 0: ack, err, rdata, mem_* and busy.
//  States and transitions:
//   - IDLE: if any req, pick the winner, latch {we,addr,wdata,size,src} and go to SERVE. An I request latches we=0, size=3.
//     - Tie (both req): grant the side not equal to last_gnt.
//     - last_gnt updates at grant time.
//   - SERVE (exactly 1 cycle):
//     - mem_* are driven from the latched request; mem_re=~we, mem_we=we.
//     - A store commits at the closing posedge.
//     - mem_rdata is registered into the source's rdata at the closing posedge, then go to RESP.
//   - RESP (exactly 1 cycle): the source's ack=1; mem_we=mem_re=0; go to IDLE.
//     - A request still asserted is only considered from IDLE, in the following cycle.
//  Timing and throughput:
//   - Fixed latency: req sampled at edge N gives ack in cycle N+2.
//   - Throughput: one transaction per 3 cycles. With both requesting continuously, grants strictly alternate.
//  Data rules:
//   - rdata is the whole word. Byte/half extraction is done by the LSU, not here.
//   - rdata holds its last value outside ack. Only the served side's rdata/err update.
//  Protocol and reset corner cases:
//   - Payload changes after grant are ignored. Dropping req before ack is a protocol violation; the transaction still completes.
//   - Reset in SERVE: the memory's write path is reset-gated, so the store is lost. No ack; state returns to IDLE.
//   - Reset in RESP: ack is suppressed that cycle.
// CONFIGURATION
//  MEM_PORT_ARB_RANGE_CHECK_EN
//   - Defined: in IDLE the latched request is marked bad if any of the following holds:
//     - addr[31:16]!=MEM_ADDR
//     - size==2
//     - size==1 && addr[0]
//     - size==3 && addr[1:0]!=0
//   - Bad requests still go through SERVE with mem_we=mem_re=0, then ack with err=1 and rdata=0.
//   - Undefined: every request is forwarded unchanged and err is tied to 0.
// STRUCTURE
//  mem_arb_pkg:
//   - size encodings SZ_BYTE/SZ_HALF/SZ_UNAL/SZ_WORD
//   - state encoding ST_IDLE/ST_SERVE/ST_RESP
//   - source ids SRC_I=0/SRC_D=1
//  Sub-module rr_arbiter2: 2-way round-robin grant from {req, last_gnt}, purely combinational; the last_gnt register lives in the parent.
// TESTING
//  1. Single load, no contention:
//     - Memory word 0x10000010 preloaded with 0xDEADBEEF; d_req, d_we=0, addr=0x10000010, size=3 at edge 0.
//     - Required: d_ack in cycle 2, d_rdata=0xDEADBEEF, d_err=0, mem_re=1 only in cycle 1.
//  2. Byte store then load:
//     - Store d_wdata=0x000000AB, size=0, addr=0x10000021; then load 0x10000020 size=3 (word previously 0).
//     - Required: d_rdata=0x0000AB00.
//  3. Contention from reset:
//     - i_req and d_req both asserted continuously.
//     - Required: grants I, D, I, D; acks in cycles 2, 5, 8, 11; busy low only on the IDLE cycles.
//  4. Reset mid-operation:
//     - reset=1 during SERVE of a store of 0x12345678 to 0x10000040.
//     - Required: no d_ack, all outputs 0, word unchanged; the next request completes normally.
//  5. Range check (MEM_PORT_ARB_RANGE_CHECK_EN defined):
//     - d store to 0x20000000, then word load at 0x10000002.
//     - Required: both ack with d_err=1, d_rdata=0, mem_we/mem_re never asserted.
//     - Macro undefined: err stays 0.
//  6. Payload stability:
//     - Change d_addr in cycle 1 after grant.
//     - Required: the memory access uses the address latched at grant.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types for the I/D memory port arbiter: size codes, FSM states, source ids,
// the latched request record and the address/size legality check.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_UNAL = 2'd2,
        SZ_WORD = 2'd3
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SERVE = 2'd1,
        ST_RESP  = 2'd2
    } state_e;

    typedef enum logic {
        SRC_I = 1'b0,
        SRC_D = 1'b1
    } src_e;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        size_e       size;
        src_e        src;
        logic        bad;
    } req_t;

    // Outside the memory region, or misaligned for its access size.
    function automatic logic req_is_bad(input logic [31:0] addr, input size_e size,
                                        input logic [15:0] region);
        return (addr[31:16] != region) ||
               (size == SZ_UNAL) ||
               ((size == SZ_HALF) && addr[0]) ||
               ((size == SZ_WORD) && (addr[1:0] != 2'b00));
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the fetch/LSU requesters, the arbiter and the memory instance.
// slave = arbiter view, master = core + memory view.
interface mem_port_arbiter_if;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_ack;
    logic [31:0] i_rdata;
    logic        i_err;

    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [1:0]  d_size;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic        d_err;

    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [1:0]  mem_size;
    logic        mem_we;
    logic        mem_re;
    logic [31:0] mem_rdata;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_size, mem_rdata,
        output i_ack, i_rdata, i_err, d_ack, d_rdata, d_err,
               mem_addr, mem_wdata, mem_size, mem_we, mem_re
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_size, mem_rdata,
        input  i_ack, i_rdata, i_err, d_ack, d_rdata, d_err,
               mem_addr, mem_wdata, mem_size, mem_we, mem_re
    );
endinterface

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant; purely combinational, the last-grant register lives in the parent.
module rr_arbiter2
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,       // bit SRC_I = fetch, bit SRC_D = load/store
    input  src_e       last_gnt,
    output logic       gnt_valid,
    output src_e       gnt_src
);

    always_comb begin
        gnt_valid = |req;
        gnt_src   = SRC_I;
        if (req[1] && req[0]) begin
            gnt_src = (last_gnt == SRC_I) ? SRC_D : SRC_I;
        end else if (req[1]) begin
            gnt_src = SRC_D;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing the single-ported memory between fetch (I) and load/store (D).
// Optional build macro MEM_PORT_ARB_RANGE_CHECK_EN rejects out-of-region/misaligned requests.
//
// state    | meaning
// ST_IDLE  | waiting for a request; winner is latched on the closing edge
// ST_SERVE | memory driven from the latched request; read data captured on the closing edge
// ST_RESP  | one-cycle ack to the served source; memory strobes low
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter logic [15:0] MEM_ADDR = 16'h1000,
    parameter logic        RR_INIT  = 1'b1
) (
    input  logic                clock,
    input  logic                reset,
    mem_port_arbiter_if.slave   bus,
    output logic                busy
);

`ifdef MEM_PORT_ARB_RANGE_CHECK_EN
    localparam logic RANGE_CHECK = 1'b1;
`else
    localparam logic RANGE_CHECK = 1'b0;
`endif

    state_e state;
    state_e state_nxt;
    src_e   last_gnt;
    req_t   lat;
    req_t   req_win;
    logic   gnt_valid;
    src_e   gnt_src;

    rr_arbiter2 u_rr (
        .req       ({bus.d_req, bus.i_req}),
        .last_gnt  (last_gnt),
        .gnt_valid (gnt_valid),
        .gnt_src   (gnt_src)
    );

    // Fetches are always word reads.
    always_comb begin
        if (gnt_src == SRC_D) begin
            req_win = '{we: bus.d_we, addr: bus.d_addr, wdata: bus.d_wdata,
                        size: size_e'(bus.d_size), src: SRC_D, bad: 1'b0};
        end else begin
            req_win = '{we: 1'b0, addr: bus.i_addr, wdata: 32'h0,
                        size: SZ_WORD, src: SRC_I, bad: 1'b0};
        end
        req_win.bad = RANGE_CHECK & req_is_bad(req_win.addr, req_win.size, MEM_ADDR);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= ST_IDLE;
            last_gnt <= src_e'(RR_INIT);
            lat      <= '0;
        end else begin
            state <= state_nxt;
            if ((state == ST_IDLE) && gnt_valid) begin
                lat      <= req_win;
                last_gnt <= gnt_src;
            end
        end
    end

    // Only the served side's data/err registers move; both hold outside their ack.
    always_ff @(posedge clock) begin
        if (reset) begin
            bus.i_rdata <= '0;
            bus.i_err   <= 1'b0;
            bus.d_rdata <= '0;
            bus.d_err   <= 1'b0;
        end else if (state == ST_SERVE) begin
            if (lat.src == SRC_I) begin
                bus.i_rdata <= lat.bad ? 32'h0 : bus.mem_rdata;
                bus.i_err   <= lat.bad;
            end else begin
                bus.d_rdata <= lat.bad ? 32'h0 : bus.mem_rdata;
                bus.d_err   <= lat.bad;
            end
        end
    end

    always_comb begin
        state_nxt     = state;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.mem_size  = '0;
        bus.mem_we    = 1'b0;
        bus.mem_re    = 1'b0;
        bus.i_ack     = 1'b0;
        bus.d_ack     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (gnt_valid) state_nxt = ST_SERVE;
            end
            ST_SERVE: begin
                state_nxt = ST_RESP;
                if (!reset) begin
                    bus.mem_addr  = lat.addr;
                    bus.mem_wdata = lat.wdata;
                    bus.mem_size  = lat.size;
                    bus.mem_we    = lat.we & ~lat.bad;
                    bus.mem_re    = ~lat.we & ~lat.bad;
                end
            end
            ST_RESP: begin
                state_nxt = ST_IDLE;
                if (!reset) begin
                    bus.i_ack = (lat.src == SRC_I);
                    bus.d_ack = (lat.src == SRC_D);
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: behavioural memory, reference memory and
// per-source expected-response queues checked on every ack.
module tb_mem_port_arbiter;

    logic clock = 1'b0;
    logic reset;
    logic busy;

    mem_port_arbiter_if bus ();

    mem_port_arbiter dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus),
        .busy  (busy)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic [31:0] mem_model [0:1023];
    logic [31:0] ref_mem   [0:1023];
    exp_t        i_q [$];
    exp_t        d_q [$];
    exp_t        mon_e;
    int          n_checks = 0;
    int          n_errors = 0;

    assign bus.mem_rdata = mem_model[bus.mem_addr[11:2]];

    // Memory instance: write path gated by reset.
    always @(posedge clock) begin
        if (!reset && bus.mem_we) begin
            case (bus.mem_size)
                2'd0:    mem_model[bus.mem_addr[11:2]][8*bus.mem_addr[1:0] +: 8] <= bus.mem_wdata[7:0];
                2'd1:    mem_model[bus.mem_addr[11:2]][16*bus.mem_addr[1] +: 16] <= bus.mem_wdata[15:0];
                default: mem_model[bus.mem_addr[11:2]] <= bus.mem_wdata;
            endcase
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", tag, act, exp);
        end
    endtask

    function automatic bit exp_bad(input logic [31:0] addr, input logic [1:0] size);
`ifdef MEM_PORT_ARB_RANGE_CHECK_EN
        return (addr[31:16] != 16'h1000) || (size == 2'd2) ||
               ((size == 2'd1) && addr[0]) || ((size == 2'd3) && (addr[1:0] != 2'b00));
`else
        return 1'b0;
`endif
    endfunction

    task automatic preload(input int idx, input logic [31:0] val);
        mem_model[idx] = val;
        ref_mem[idx]   = val;
    endtask

    task automatic push_d(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [1:0] size);
        exp_t e;
        bit   bad;
        bad     = exp_bad(addr, size);
        e.err   = bad;
        e.rdata = bad ? 32'h0 : ref_mem[addr[11:2]];
        d_q.push_back(e);
        if (we && !bad) begin
            case (size)
                2'd0:    ref_mem[addr[11:2]][8*addr[1:0] +: 8] = wdata[7:0];
                2'd1:    ref_mem[addr[11:2]][16*addr[1] +: 16] = wdata[15:0];
                default: ref_mem[addr[11:2]] = wdata;
            endcase
        end
    endtask

    task automatic push_i(input logic [31:0] addr);
        exp_t e;
        e.err   = exp_bad(addr, 2'd3);
        e.rdata = e.err ? 32'h0 : ref_mem[addr[11:2]];
        i_q.push_back(e);
    endtask

    always @(negedge clock) begin
        if (bus.d_ack === 1'b1) begin
            if (d_q.size() == 0) begin
                check_eq("d_ack_unexpected", 32'd1, 32'd0);
            end else begin
                mon_e = d_q.pop_front();
                check_eq("d_rdata", bus.d_rdata, mon_e.rdata);
                check_eq("d_err", 32'(bus.d_err), 32'(mon_e.err));
            end
        end
        if (bus.i_ack === 1'b1) begin
            if (i_q.size() == 0) begin
                check_eq("i_ack_unexpected", 32'd1, 32'd0);
            end else begin
                mon_e = i_q.pop_front();
                check_eq("i_rdata", bus.i_rdata, mon_e.rdata);
                check_eq("i_err", 32'(bus.i_err), 32'(mon_e.err));
            end
        end
    end

    // Called at posedge+1 of an IDLE cycle (cycle 0); records strobes per cycle until the ack.
    task automatic run_d(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [1:0] size, input bit perturb, output int ack_cyc,
                         output logic [15:0] re_mask, output logic [15:0] we_mask,
                         output logic [31:0] srv_addr);
        push_d(we, addr, wdata, size);
        bus.d_req   = 1'b1;
        bus.d_we    = we;
        bus.d_addr  = addr;
        bus.d_wdata = wdata;
        bus.d_size  = size;
        ack_cyc     = -1;
        re_mask     = '0;
        we_mask     = '0;
        srv_addr    = '0;
        for (int c = 0; c < 16; c++) begin
            @(negedge clock);
            if (bus.mem_re) re_mask[c] = 1'b1;
            if (bus.mem_we) we_mask[c] = 1'b1;
            if (c == 1) srv_addr = bus.mem_addr;
            if (bus.d_ack) begin
                ack_cyc = c;
                break;
            end
            @(posedge clock);
            #1;
            if (perturb && c == 0) bus.d_addr = addr ^ 32'h0000_0040;
        end
        if (ack_cyc < 0) check_eq("d_timeout", 32'd0, 32'd1);
        @(posedge clock);
        #1;
        bus.d_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1);
    end

    initial begin
        int          ack_cyc;
        logic [15:0] re_m;
        logic [15:0] we_m;
        logic [31:0] s_addr;
        logic [12:0] i_bits;
        logic [12:0] d_bits;
        logic [12:0] b_bits;

        for (int k = 0; k < 1024; k++) preload(k, 32'h0);
        preload(32'h010 >> 2, 32'hDEADBEEF);
        preload(32'h040 >> 2, 32'hCAFEF00D);
        preload(32'h100 >> 2, 32'h11112222);
        preload(32'h200 >> 2, 32'h33334444);

        bus.i_req = 1'b0; bus.i_addr = '0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0; bus.d_size = '0;
        reset = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_d_ack", 32'(bus.d_ack), 32'd0);
        check_eq("rst_i_ack", 32'(bus.i_ack), 32'd0);
        check_eq("rst_d_rdata", bus.d_rdata, 32'h0);
        check_eq("rst_i_rdata", bus.i_rdata, 32'h0);
        check_eq("rst_mem_strobes", 32'({bus.mem_we, bus.mem_re}), 32'd0);
        check_eq("rst_mem_addr", bus.mem_addr, 32'h0);
        @(posedge clock);
        #1;
        reset = 1'b0;

        // Single load
        run_d(1'b0, 32'h1000_0010, 32'h0, 2'd3, 1'b0, ack_cyc, re_m, we_m, s_addr);
        check_eq("t1_ack_cycle", 32'(ack_cyc), 32'd2);
        check_eq("t1_re_mask", 32'(re_m), 32'h0002);
        check_eq("t1_we_mask", 32'(we_m), 32'h0000);
        @(negedge clock);
        check_eq("t1_rdata_hold", bus.d_rdata, 32'hDEADBEEF);
        check_eq("t1_i_rdata_untouched", bus.i_rdata, 32'h0);
        @(posedge clock);
        #1;

        // Byte store then word load
        run_d(1'b1, 32'h1000_0021, 32'h0000_00AB, 2'd0, 1'b0, ack_cyc, re_m, we_m, s_addr);
        check_eq("t2_we_mask", 32'(we_m), 32'h0002);
        run_d(1'b0, 32'h1000_0020, 32'h0, 2'd3, 1'b0, ack_cyc, re_m, we_m, s_addr);
        check_eq("t2_word", bus.d_rdata, 32'h0000AB00);

        // Contention from reset
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        push_i(32'h1000_0100);
        push_i(32'h1000_0100);
        push_d(1'b0, 32'h1000_0200, 32'h0, 2'd3);
        push_d(1'b0, 32'h1000_0200, 32'h0, 2'd3);
        bus.i_req = 1'b1; bus.i_addr = 32'h1000_0100;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h1000_0200; bus.d_size = 2'd3;
        for (int c = 0; c < 13; c++) begin
            @(negedge clock);
            i_bits[c] = bus.i_ack;
            d_bits[c] = bus.d_ack;
            b_bits[c] = busy;
            @(posedge clock);
            #1;
            if (c == 11) begin
                bus.i_req = 1'b0;
                bus.d_req = 1'b0;
            end
        end
        check_eq("t3_i_ack_cycles", 32'(i_bits), 32'h0104);
        check_eq("t3_d_ack_cycles", 32'(d_bits), 32'h0820);
        check_eq("t3_busy_cycles", 32'(b_bits), 32'h0DB6);

        // Reset during SERVE of a store
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h1000_0040;
        bus.d_wdata = 32'h1234_5678; bus.d_size = 2'd3;
        @(posedge clock);
        #1;
        reset = 1'b1;
        bus.d_req = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        check_eq("t4_d_ack", 32'(bus.d_ack), 32'd0);
        check_eq("t4_busy", 32'(busy), 32'd0);
        check_eq("t4_d_rdata", bus.d_rdata, 32'h0);
        check_eq("t4_mem_strobes", 32'({bus.mem_we, bus.mem_re}), 32'd0);
        check_eq("t4_word_kept", mem_model[32'h040 >> 2], 32'hCAFEF00D);
        @(posedge clock);
        #1;
        run_d(1'b0, 32'h1000_0040, 32'h0, 2'd3, 1'b0, ack_cyc, re_m, we_m, s_addr);
        check_eq("t4_next_ack_cycle", 32'(ack_cyc), 32'd2);

        // Range check
        run_d(1'b1, 32'h2000_0000, 32'h55AA_55AA, 2'd3, 1'b0, ack_cyc, re_m, we_m, s_addr);
`ifdef MEM_PORT_ARB_RANGE_CHECK_EN
        check_eq("t5_store_err", 32'(bus.d_err), 32'd1);
        check_eq("t5_store_strobes", 32'(re_m | we_m), 32'h0);
`else
        check_eq("t5_store_err", 32'(bus.d_err), 32'd0);
        check_eq("t5_store_we_mask", 32'(we_m), 32'h0002);
`endif
        run_d(1'b0, 32'h1000_0002, 32'h0, 2'd3, 1'b0, ack_cyc, re_m, we_m, s_addr);
`ifdef MEM_PORT_ARB_RANGE_CHECK_EN
        check_eq("t5_load_err", 32'(bus.d_err), 32'd1);
        check_eq("t5_load_rdata", bus.d_rdata, 32'h0);
        check_eq("t5_load_strobes", 32'(re_m | we_m), 32'h0);
`else
        check_eq("t5_load_err", 32'(bus.d_err), 32'd0);
        check_eq("t5_load_re_mask", 32'(re_m), 32'h0002);
`endif

        // Payload change after grant
        run_d(1'b0, 32'h1000_0010, 32'h0, 2'd3, 1'b1, ack_cyc, re_m, we_m, s_addr);
        check_eq("t6_served_addr", s_addr, 32'h1000_0010);
        check_eq("t6_ack_cycle", 32'(ack_cyc), 32'd2);

        repeat (3) @(posedge clock);
        check_eq("i_queue_drained", 32'(i_q.size()), 32'd0);
        check_eq("d_queue_drained", 32'(d_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
